// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port: register word addresses and default prescaler.
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_DATA = 3'd0,
    GPIO_DIR  = 3'd1,
    GPIO_RISE = 3'd2,
    GPIO_FALL = 3'd3,
    GPIO_PEND = 3'd4,
    GPIO_IEN  = 3'd5,
    GPIO_SET  = 3'd6,
    GPIO_CLR  = 3'd7
  } gpio_reg_e;

  // 1 ms debounce sample period at 25 MHz
  localparam int GPIO_DIV_DEFAULT = 25000;

endpackage

// File: rtl/gpio_port_if.sv
// Processor I/O bus slice seen by the GPIO port: strobes, word address and data.
interface gpio_port_if;
  logic        wr;
  logic        rd;
  logic [2:0]  adr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wr, rd, adr, wdata, input rdata);
  modport slave  (input wr, rd, adr, wdata, output rdata);
endinterface

// File: rtl/gpio_filter.sv
// One pin input path: two-flop synchroniser followed by a tick-sampled majority-free
// debounce that only accepts a level seen on FILT_LEN consecutive samples.
module gpio_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_pin,
  output logic o_filt
);

  logic r_meta;
  logic r_sync;
  logic r_filt;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchroniser into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  generate
    if (FILT_LEN == 0) begin : g_bypass
      logic w_unused_tick;
      assign w_unused_tick = i_tick;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_filt <= 1'b0;
        else      r_filt <= r_sync;
      end
    end else if (FILT_LEN == 1) begin : g_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_filt <= 1'b0;
        else if (i_tick) r_filt <= r_sync;
      end
    end else begin : g_history
      // Only the older FILT_LEN-1 samples are stored; the newest is r_sync itself.
      logic [FILT_LEN-2:0] r_hist;
      logic [FILT_LEN-1:0] w_next;
      assign w_next = {r_hist, r_sync};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_hist <= '0;
          r_filt <= 1'b0;
        end else if (i_tick) begin
          r_hist <= w_next[FILT_LEN-2:0];
          if ((&w_next) || !(|w_next)) r_filt <= w_next[0];
        end
      end
    end
  endgenerate

  assign o_filt = r_filt;

endmodule

// File: rtl/gpio_port.sv
// WIDTH-pin GPIO controller: output latch with set/clear, direction mask,
// debounced inputs, per-pin edge capture and a maskable registered interrupt.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIV      = GPIO_DIV_DEFAULT,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] r_filt_d;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_ien;
  logic             r_irq;
  logic [WIDTH-1:0] w_wmask;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_pend_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wmask  = bus.wdata[WIDTH-1:0];
  assign w_unused = &{1'b0, bus.rd, bus.wdata};

  // Shared debounce sample clock: one tick per DIV cycles, on the wrap.
  assign w_tick = (r_presc == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_filter #(.FILT_LEN(FILT_LEN)) u_filter (
      .clk    (clk),
      .rst    (rst),
      .i_tick (w_tick),
      .i_pin  (pin_in[i]),
      .o_filt (w_filt[i])
    );
  end

  assign w_event    = (w_filt & ~r_filt_d & r_rise) | (~w_filt & r_filt_d & r_fall);
  assign w_pend_clr = (bus.wr && (bus.adr == GPIO_PEND)) ? w_wmask : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_ien    <= '0;
      r_pend   <= '0;
      r_filt_d <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_filt_d <= w_filt;
      // A new edge outranks a same-cycle clear so no event is ever lost.
      r_pend   <= (r_pend & ~w_pend_clr) | w_event;
      r_irq    <= |(r_pend & r_ien);
      if (bus.wr) begin
        case (gpio_reg_e'(bus.adr))
          GPIO_DATA: r_out  <= w_wmask;
          GPIO_DIR:  r_dir  <= w_wmask;
          GPIO_RISE: r_rise <= w_wmask;
          GPIO_FALL: r_fall <= w_wmask;
          GPIO_IEN:  r_ien  <= w_wmask;
          GPIO_SET:  r_out  <= r_out | w_wmask;
          GPIO_CLR:  r_out  <= r_out & ~w_wmask;
          default:   ;
        endcase
      end
    end
  end

  // NOTE: w_rdata gets a full default before the case so every path assigns
  // every bit; leaving any bit unassigned on some path would infer a latch.
  always_comb begin
    w_rdata = '0;
    case (gpio_reg_e'(bus.adr))
      GPIO_DATA: w_rdata[WIDTH-1:0] = w_filt;
      GPIO_DIR:  w_rdata[WIDTH-1:0] = r_dir;
      GPIO_RISE: w_rdata[WIDTH-1:0] = r_rise;
      GPIO_FALL: w_rdata[WIDTH-1:0] = r_fall;
      GPIO_PEND: w_rdata[WIDTH-1:0] = r_pend;
      GPIO_IEN:  w_rdata[WIDTH-1:0] = r_ien;
      default:   w_rdata = '0;
    endcase
  end

  assign bus.rdata = w_rdata;
  assign pin_out   = r_out;
  assign pin_oe    = r_dir;
  assign irq       = r_irq;

endmodule
